sr_flag_arbiter: RTL and testbench

- Shares a bank of NFLAG clocked SR flag flip-flops between NREQ requesters.
- Each requester asks to set or reset one flag. The block grants requests round-robin and drives exactly one s or r line at a time as a PW-cycle pulse, so s=r=1 never occurs on any flag.
- Keeps a shadow copy of every flag's q. A command that would not change the flag completes without driving the bank.

---
 rtl/sr_flag_arbiter_if.sv | 25 ++
 rtl/sr_flag_arbiter.sv | 140 ++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side handshake bundle for sr_flag_arbiter: per-requester command
// inputs plus the registered one-hot grant returned by the arbiter.
interface sr_flag_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      gnt;

    modport master (
        output req,
        output req_op,
        output req_idx,
        input  gnt
    );

    modport slave (
        input  req,
        input  req_op,
        input  req_idx,
        output gnt
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares a bank of clocked SR flags between requesters,
// pulsing exactly one s or r line at a time and skipping commands the shadow shows as no-ops.
module sr_flag_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8,
    parameter int unsigned IDXW  = 3,
    parameter int unsigned PW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sr_flag_arbiter_if.slave bus,
    output logic [NFLAG-1:0] s_out,
    output logic [NFLAG-1:0] r_out,
    output logic [NFLAG-1:0] q_shadow,
    output logic             busy
);
    localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_e;

    state_e            state_q, state_d;
    logic [RRW-1:0]    rr_q, rr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NFLAG-1:0]  s_q, s_d;
    logic [NFLAG-1:0]  r_q, r_d;
    logic [NFLAG-1:0]  shadow_q, shadow_d;

    logic [IDXW-1:0]   idx_arr [NREQ];
    logic              found;
    logic [RRW-1:0]    win;
    logic [IDXW-1:0]   win_idx;
    logic              win_op;
    logic              effective;

    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_arr[k] = bus.req_idx[k*IDXW +: IDXW];
        end
    end

    // Two passes avoid a modulo: first requesters at or above the pointer,
    // then wrap to the lowest requester below it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && bus.req[k] && (RRW'(k) >= rr_q)) begin
                found = 1'b1;
                win   = RRW'(k);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && bus.req[k]) begin
                found = 1'b1;
                win   = RRW'(k);
            end
        end
    end

    always_comb begin
        win_idx   = idx_arr[win];
        win_op    = bus.req_op[win];
        effective = (32'(win_idx) < NFLAG) && (shadow_q[win_idx] != win_op);
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        s_d      = s_q;
        r_d      = r_q;
        shadow_d = shadow_q;

        case (state_q)
            IDLE: begin
                s_d = '0;
                r_d = '0;
                if (found) begin
                    gnt_d[win] = 1'b1;
                    rr_d       = (32'(win) == NREQ - 1) ? '0 : win + RRW'(1);
                    if (effective) begin
                        state_d           = DRIVE;
                        cnt_d             = 4'(PW - 1);
                        shadow_d[win_idx] = win_op;
                        if (win_op) begin
                            s_d[win_idx] = 1'b1;
                        end else begin
                            r_d[win_idx] = 1'b1;
                        end
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    s_d     = '0;
                    r_d     = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign s_out    = s_q;
    assign r_out    = r_q;
    assign q_shadow = shadow_q;
    assign busy     = (state_q == DRIVE);
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: two instances (PW=1/NFLAG=8 and PW=3/NFLAG=6) checked
// cycle by cycle against a counter/array reference model, plus directed scenarios.
module tb_sr_flag_arbiter;
    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus_a ();
    sr_flag_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus_b ();

    logic [7:0] s_a, r_a, sh_a;
    logic       busy_a;
    logic [5:0] s_b, r_b, sh_b;
    logic       busy_b;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3), .PW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .s_out(s_a), .r_out(r_a), .q_shadow(sh_a), .busy(busy_a)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3), .PW(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .s_out(s_b), .r_out(r_b), .q_shadow(sh_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: remaining drive cycles, pointer and flag array per instance.
    int         m_rr   [2];
    int         m_left [2];
    int         m_didx [2];
    logic       m_dop  [2];
    logic [7:0] m_sh   [2];
    logic [3:0] e_gnt  [2];

    logic [3:0]  st_req [2];
    logic [3:0]  st_op  [2];
    logic [11:0] st_idx [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rr[i]   = 0;
            m_left[i] = 0;
            m_didx[i] = 0;
            m_dop[i]  = 1'b0;
            m_sh[i]   = '0;
            e_gnt[i]  = '0;
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] req, input logic [3:0] op,
                              input logic [11:0] idx);
        int w, ix, nf, pw;
        nf = (i == 0) ? 8 : 6;
        pw = (i == 0) ? 1 : 3;
        e_gnt[i] = '0;
        if (m_left[i] > 0) begin
            m_left[i]--;
        end else if (req != 4'b0) begin
            w = -1;
            for (int off = 0; off < 4; off++) begin
                if (w < 0 && req[(m_rr[i] + off) % 4]) w = (m_rr[i] + off) % 4;
            end
            e_gnt[i] = 4'(1 << w);
            m_rr[i]  = (w + 1) % 4;
            ix = int'((idx >> (3 * w)) & 12'h7);
            if (ix < nf && m_sh[i][ix] != op[w]) begin
                m_sh[i][ix] = op[w];
                m_left[i]   = pw;
                m_didx[i]   = ix;
                m_dop[i]    = op[w];
            end
        end
    endtask

    function automatic logic [7:0] exp_s(input int i);
        return (m_left[i] > 0 && m_dop[i]) ? 8'(1 << m_didx[i]) : 8'h00;
    endfunction

    function automatic logic [7:0] exp_r(input int i);
        return (m_left[i] > 0 && !m_dop[i]) ? 8'(1 << m_didx[i]) : 8'h00;
    endfunction

    task automatic check_all();
        check("a_gnt",    32'(bus_a.gnt), 32'(e_gnt[0]));
        check("a_s",      32'(s_a),       32'(exp_s(0)));
        check("a_r",      32'(r_a),       32'(exp_r(0)));
        check("a_busy",   32'(busy_a),    32'(m_left[0] > 0));
        check("a_shadow", 32'(sh_a),      32'(m_sh[0]));
        check("b_gnt",    32'(bus_b.gnt), 32'(e_gnt[1]));
        check("b_s",      32'(s_b),       32'(exp_s(1)));
        check("b_r",      32'(r_b),       32'(exp_r(1)));
        check("b_busy",   32'(busy_b),    32'(m_left[1] > 0));
        check("b_shadow", 32'(sh_b),      32'(m_sh[1]));
        check("a_one_line",   32'($countones(s_a | r_a) <= 1), 32'd1);
        check("a_sr_excl",    32'(s_a & r_a),                 32'd0);
        check("a_gnt_onehot", 32'($onehot0(bus_a.gnt)),       32'd1);
        check("b_one_line",   32'($countones(s_b | r_b) <= 1), 32'd1);
        check("b_sr_excl",    32'(s_b & r_b),                 32'd0);
        check("b_gnt_onehot", 32'($onehot0(bus_b.gnt)),       32'd1);
    endtask

    task automatic apply();
        bus_a.req = st_req[0]; bus_a.req_op = st_op[0]; bus_a.req_idx = st_idx[0];
        bus_b.req = st_req[1]; bus_b.req_op = st_op[1]; bus_b.req_idx = st_idx[1];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, bus_a.req, bus_a.req_op, bus_a.req_idx);
            model_step(1, bus_b.req, bus_b.req_op, bus_b.req_idx);
        end
        #1;
        cyc++;
        check_all();
    endtask

    task automatic new_cmd(input int i, input int k);
        st_op[i][k]            = 1'($urandom_range(1, 0));
        st_idx[i][k*3 +: 3]    = 3'($urandom_range(7, 0));
    endtask

    task automatic rand_update(input int i);
        for (int k = 0; k < 4; k++) begin
            if (e_gnt[i][k]) begin
                if ($urandom_range(1, 0) == 0) st_req[i][k] = 1'b0;
                else new_cmd(i, k);
            end else if (!st_req[i][k]) begin
                if ($urandom_range(3, 0) == 0) begin
                    st_req[i][k] = 1'b1;
                    new_cmd(i, k);
                end
            end else if ($urandom_range(31, 0) == 0) begin
                st_req[i][k] = 1'b0;
            end
        end
    endtask

    int         gc[$];
    logic [3:0] gq[$];
    int         hi;
    logic [5:0] sh_before;

    initial begin
        for (int i = 0; i < 2; i++) begin
            st_req[i] = '0; st_op[i] = '0; st_idx[i] = '0;
        end
        model_reset();
        apply();
        cycle();
        cycle();
        rst_n = 1'b1;

        // Fairness on A: all four request distinct effective commands.
        st_req[0] = 4'b1111;
        st_op[0]  = 4'b1111;
        st_idx[0] = {3'd3, 3'd2, 3'd1, 3'd0};
        apply();
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (bus_a.gnt != 4'b0) begin
                gq.push_back(bus_a.gnt);
                gc.push_back(c);
            end
            for (int k = 0; k < 4; k++) if (e_gnt[0][k]) st_op[0][k] = ~st_op[0][k];
            apply();
        end
        check("fair_count", 32'(gq.size()), 32'd5);
        for (int j = 0; j < gq.size() && j < 5; j++) begin
            check("fair_order", 32'(gq[j]), 32'(1 << (j % 4)));
            if (j > 0) check("fair_spacing", 32'(gc[j] - gc[j-1]), 32'd2);
            else       check("fair_latency", 32'(gc[j]), 32'd0);
        end
        st_req[0] = '0;
        apply();
        cycle();

        // A: requester 0 sets flag 5.
        st_req[0] = 4'b0001; st_op[0][0] = 1'b1; st_idx[0][2:0] = 3'd5;
        apply();
        cycle();
        check("t1_gnt",  32'(bus_a.gnt), 32'h1);
        check("t1_s",    32'(s_a),       32'h20);
        check("t1_busy", 32'(busy_a),    32'h1);
        st_req[0] = '0;
        apply();
        cycle();
        check("t1_s_off",   32'(s_a),    32'h0);
        check("t1_busy_off", 32'(busy_a), 32'h0);
        check("t1_shadow5", 32'(sh_a[5]), 32'h1);

        // A: redundant set on flag 5, then an immediate grant on the next edge.
        st_req[0] = 4'b0100; st_op[0][2] = 1'b1; st_idx[0][8:6] = 3'd5;
        apply();
        cycle();
        check("t3_gnt",  32'(bus_a.gnt),  32'h4);
        check("t3_sr",   32'(s_a | r_a),  32'h0);
        check("t3_busy", 32'(busy_a),     32'h0);
        st_req[0] = 4'b0001; st_op[0][0] = 1'b0; st_idx[0][2:0] = 3'd1;
        apply();
        cycle();
        check("t3_next_gnt", 32'(bus_a.gnt), 32'h1);
        check("t3_next_r",   32'(r_a),       32'h02);
        st_req[0] = '0;
        apply();
        cycle();

        // B (PW=3): set flag 5, then reset it with requester 3 raised during the drive.
        st_req[1] = 4'b0001; st_op[1][0] = 1'b1; st_idx[1][2:0] = 3'd5;
        apply();
        cycle();
        st_req[1] = '0;
        apply();
        repeat (3) cycle();
        st_req[1] = 4'b0010; st_op[1][1] = 1'b0; st_idx[1][5:3] = 3'd5;
        apply();
        cycle();
        check("t4_gnt", 32'(bus_b.gnt), 32'h2);
        check("t4_r",   32'(r_b),       32'h20);
        st_req[1] = 4'b1000; st_op[1][3] = 1'b1; st_idx[1][11:9] = 3'd2;
        apply();
        hi = 1;
        repeat (3) begin
            cycle();
            if (r_b == 6'h20) hi++;
        end
        check("t4_pulse_len", 32'(hi),         32'd3);
        check("t4_idle_gnt",  32'(bus_b.gnt),  32'h0);
        check("t4_idle_busy", 32'(busy_b),     32'h0);
        cycle();
        check("t4_wait_gnt", 32'(bus_b.gnt), 32'h8);
        check("t4_wait_s",   32'(s_b),       32'h04);
        st_req[1] = '0;
        apply();
        repeat (3) cycle();

        // B (NFLAG=6): out-of-range index 7 is granted and dropped.
        sh_before = sh_b;
        st_req[1] = 4'b0001; st_op[1][0] = 1'b1; st_idx[1][2:0] = 3'd7;
        apply();
        cycle();
        check("t5_gnt",    32'(bus_b.gnt), 32'h1);
        check("t5_sr",     32'(s_b | r_b), 32'h0);
        check("t5_busy",   32'(busy_b),    32'h0);
        check("t5_shadow", 32'(sh_b),      32'(sh_before));
        st_req[1] = '0;
        apply();
        cycle();

        // B: reset asserted in the second cycle of a PW=3 drive.
        st_req[1] = 4'b0010; st_op[1][1] = 1'b0; st_idx[1][5:3] = 3'd2;
        apply();
        cycle();
        check("t6_r", 32'(r_b), 32'h04);
        st_req[1] = 4'b1010;
        st_op[1][1] = 1'b1; st_idx[1][5:3]  = 3'd0;
        st_op[1][3] = 1'b1; st_idx[1][11:9] = 3'd1;
        apply();
        cycle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_r",      32'(r_b),       32'h0);
        check("t6_rst_busy",   32'(busy_b),    32'h0);
        check("t6_rst_gnt",    32'(bus_b.gnt), 32'h0);
        check("t6_rst_shadow", 32'(sh_b),      32'h0);
        check_all();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("t6_first_gnt", 32'(bus_b.gnt), 32'h2);
        check("t6_first_s",   32'(s_b),       32'h01);

        // Random traffic on both instances with the reference model.
        for (int n = 0; n < 1500; n++) begin
            rand_update(0);
            rand_update(1);
            apply();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
